// File: rtl/vga_fb_pkg.sv
// Shared types and constants for the VGA frame-buffer arbiter: pixel/address
// types, the fetch FSM state encoding and the default frame geometry.
package vga_fb_pkg;

  typedef logic [15:0] pixel_t;
  typedef logic [19:0] fb_addr_t;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FETCH = 2'd1,
    DONE  = 2'd2
  } fb_state_e;

  localparam int H_ACTIVE_DFLT = 640;
  localparam int V_ACTIVE_DFLT = 480;
  localparam int FB_WORDS      = H_ACTIVE_DFLT * V_ACTIVE_DFLT;
  localparam int FCNT_W        = 19;

  // Index of the last word of a frame, in fetch-counter width.
  function automatic logic [FCNT_W-1:0] last_index(input int words);
    return FCNT_W'(words - 1);
  endfunction

endpackage

// File: rtl/vga_fb_arbiter_if.sv
// Bus bundle between the arbiter, the pixel pipeline, the drawing engine and
// the SRAM pins. underrun_cnt exists only with VGA_FB_UNDERRUN_CNT_EN.
interface vga_fb_arbiter_if;
  import vga_fb_pkg::*;

  logic      frame_start;
  logic      pix_pop;
  pixel_t    pix_data;
  logic      pix_valid;
  // wr_req may stay high; the edge that raises wr_gnt consumes the wr_addr and
  // wr_data present at that edge, so the writer presents its next word (or
  // drops wr_req) during the cycle wr_gnt is high.
  logic      wr_req;
  fb_addr_t  wr_addr;
  pixel_t    wr_data;
  logic      wr_gnt;
  fb_addr_t  sram_addr;
  logic      sram_oe_n;
  logic      sram_we_n;
  pixel_t    sram_dq_o;
  logic      sram_dq_oe;
  pixel_t    sram_dq_i;
  fb_state_e dbg_state;
  logic      dbg_underrun;
`ifdef VGA_FB_UNDERRUN_CNT_EN
  logic [15:0] underrun_cnt;
`endif

  modport slave (
    input  frame_start, pix_pop, wr_req, wr_addr, wr_data, sram_dq_i,
    output pix_data, pix_valid, wr_gnt, sram_addr, sram_oe_n, sram_we_n,
    output sram_dq_o, sram_dq_oe, dbg_state, dbg_underrun
`ifdef VGA_FB_UNDERRUN_CNT_EN
    , output underrun_cnt
`endif
  );

  modport master (
    output frame_start, pix_pop, wr_req, wr_addr, wr_data, sram_dq_i,
    input  pix_data, pix_valid, wr_gnt, sram_addr, sram_oe_n, sram_we_n,
    input  sram_dq_o, sram_dq_oe, dbg_state, dbg_underrun
`ifdef VGA_FB_UNDERRUN_CNT_EN
    , input underrun_cnt
`endif
  );

endinterface

// File: rtl/vga_fb_fifo.sv
// Synchronous FIFO (power-of-two depth) for prefetched pixels; dout reads 0
// while empty, pop on empty is ignored and flush empties it in one cycle.
module vga_fb_fifo #(
  parameter int DEPTH = 8,
  parameter int WIDTH = 16
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   flush,
  input  logic                   push,
  input  logic                   pop,
  input  logic [WIDTH-1:0]       din,
  output logic [WIDTH-1:0]       dout,
  output logic [$clog2(DEPTH):0] count
);
  localparam int PtrW = $clog2(DEPTH);
  localparam int CntW = PtrW + 1;
  localparam logic [CntW-1:0] Full = DEPTH[CntW-1:0];

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PtrW-1:0]  wr_ptr_q, rd_ptr_q;
  logic [CntW-1:0]  count_q;
  logic             do_push, do_pop;

  assign do_pop  = pop && (count_q != '0);
  assign do_push = push && ((count_q != Full) || do_pop);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else if (flush) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (do_push) wr_ptr_q <= wr_ptr_q + PtrW'(1);
      if (do_pop)  rd_ptr_q <= rd_ptr_q + PtrW'(1);
      if (do_push && !do_pop)      count_q <= count_q + CntW'(1);
      else if (do_pop && !do_push) count_q <= count_q - CntW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (do_push && !flush) mem_q[wr_ptr_q] <= din;
  end

  assign dout  = (count_q == '0) ? '0 : mem_q[rd_ptr_q];
  assign count = count_q;

endmodule

// File: rtl/vga_fb_arbiter.sv
// Frame-buffer SRAM arbiter: display prefetch vs. drawing-engine writes with a
// starvation bound. Define VGA_FB_UNDERRUN_CNT_EN to add underrun_cnt.
module vga_fb_arbiter
  import vga_fb_pkg::*;
#(
  parameter fb_addr_t FB_BASE    = 20'h00000,
  parameter int       H_ACTIVE   = H_ACTIVE_DFLT,
  parameter int       V_ACTIVE   = V_ACTIVE_DFLT,
  parameter int       FIFO_DEPTH = 8,
  parameter int       MAX_WAIT   = 16
) (
  input logic              clk,
  input logic              reset,
  vga_fb_arbiter_if.slave  bus
);
  localparam int CntW  = $clog2(FIFO_DEPTH) + 1;
  localparam int OccW  = CntW + 1;
  localparam int WaitW = $clog2(MAX_WAIT + 1);
  localparam logic [FCNT_W-1:0] LastIdx = last_index(H_ACTIVE * V_ACTIVE);

  fb_state_e         state_q, state_d;
  fb_addr_t          fetch_addr_q, fetch_addr_d;
  logic [FCNT_W-1:0] fetch_cnt_q, fetch_cnt_d;
  logic [WaitW-1:0]  wait_cnt_q, wait_cnt_d;
  logic              rd_s_q, rd_d_q;
  logic [CntW-1:0]   fifo_count;
  logic [OccW-1:0]   occupancy;
  logic              disp_req, wr_force, grant_wr, grant_rd;
  logic              fifo_push, fifo_pop, underrun;
  fb_addr_t          sram_addr_q;
  pixel_t            dq_o_q;
  logic              oe_n_q, we_n_q, dq_oe_q, gnt_q;

  // rd_s_q: read strobe on the pins; rd_d_q: its data on sram_dq_i. Both count
  // as reserved FIFO slots so a push can never find the FIFO full.
  assign occupancy = OccW'(fifo_count) + OccW'(rd_s_q) + OccW'(rd_d_q);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state_q <= IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d      = state_q;
    fetch_addr_d = fetch_addr_q;
    fetch_cnt_d  = fetch_cnt_q;
    wait_cnt_d   = wait_cnt_q;
    disp_req     = (state_q == FETCH) && (occupancy < OccW'(FIFO_DEPTH)) && !bus.frame_start;
    wr_force     = bus.wr_req && (wait_cnt_q == WaitW'(MAX_WAIT));
    grant_wr     = bus.wr_req && (wr_force || !disp_req);
    grant_rd     = disp_req && !grant_wr;

    if (!bus.wr_req || grant_wr)              wait_cnt_d = '0;
    else if (wait_cnt_q != WaitW'(MAX_WAIT))  wait_cnt_d = wait_cnt_q + WaitW'(1);

    if (grant_rd) begin
      fetch_addr_d = fetch_addr_q + fb_addr_t'(1);
      fetch_cnt_d  = fetch_cnt_q + FCNT_W'(1);
      if (fetch_cnt_q == LastIdx) state_d = DONE;
    end
    if (bus.frame_start) begin
      state_d      = FETCH;
      fetch_addr_d = FB_BASE;
      fetch_cnt_d  = '0;
    end
  end

  assign fifo_push = rd_d_q && !bus.frame_start;
  assign fifo_pop  = bus.pix_pop && !bus.frame_start && (fifo_count != '0);
  assign underrun  = bus.pix_pop && !bus.frame_start && (fifo_count == '0);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      fetch_addr_q <= FB_BASE;
      fetch_cnt_q  <= '0;
      wait_cnt_q   <= '0;
      rd_s_q       <= 1'b0;
      rd_d_q       <= 1'b0;
      sram_addr_q  <= '0;
      dq_o_q       <= '0;
      oe_n_q       <= 1'b1;
      we_n_q       <= 1'b1;
      dq_oe_q      <= 1'b0;
      gnt_q        <= 1'b0;
    end else begin
      fetch_addr_q <= fetch_addr_d;
      fetch_cnt_q  <= fetch_cnt_d;
      wait_cnt_q   <= wait_cnt_d;
      rd_s_q       <= grant_rd;
      rd_d_q       <= rd_s_q && !bus.frame_start;
      oe_n_q       <= !grant_rd;
      we_n_q       <= !grant_wr;
      dq_oe_q      <= grant_wr;
      gnt_q        <= grant_wr;
      if (grant_rd) begin
        sram_addr_q <= fetch_addr_q;
      end else if (grant_wr) begin
        sram_addr_q <= bus.wr_addr;
        dq_o_q      <= bus.wr_data;
      end
    end
  end

  vga_fb_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH ($bits(pixel_t))
  ) u_fifo (
    .clk   (clk),
    .reset (reset),
    .flush (bus.frame_start),
    .push  (fifo_push),
    .pop   (fifo_pop),
    .din   (bus.sram_dq_i),
    .dout  (bus.pix_data),
    .count (fifo_count)
  );

  assign bus.pix_valid    = (fifo_count != '0);
  assign bus.wr_gnt       = gnt_q;
  assign bus.sram_addr    = sram_addr_q;
  assign bus.sram_oe_n    = oe_n_q;
  assign bus.sram_we_n    = we_n_q;
  assign bus.sram_dq_o    = dq_o_q;
  assign bus.sram_dq_oe   = dq_oe_q;
  assign bus.dbg_state    = state_q;
  assign bus.dbg_underrun = underrun;

`ifdef VGA_FB_UNDERRUN_CNT_EN
  logic [15:0] urun_cnt_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset)                                 urun_cnt_q <= '0;
    else if (underrun && urun_cnt_q != 16'hFFFF) urun_cnt_q <= urun_cnt_q + 16'd1;
  end

  assign bus.underrun_cnt = urun_cnt_q;
`endif

endmodule

// File: tb/tb_vga_fb_arbiter.sv
// Bench for vga_fb_arbiter: default-geometry instance plus a 4x2 instance for
// end-of-frame behaviour. Covers VGA_FB_UNDERRUN_CNT_EN when it is defined.
`timescale 1ns/1ps
module tb_vga_fb_arbiter;
  import vga_fb_pkg::*;

  localparam fb_addr_t FB_BASE  = 20'h00000;
  localparam int       MAX_WAIT = 16;

  logic clk   = 1'b0;
  logic reset = 1'b1;
  int   n_checks = 0;
  int   n_errors = 0;
  int   cyc = 0;

  vga_fb_arbiter_if bus ();
  vga_fb_arbiter_if sbus ();

  vga_fb_arbiter #(.FB_BASE(FB_BASE), .MAX_WAIT(MAX_WAIT)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  vga_fb_arbiter #(.FB_BASE(FB_BASE), .H_ACTIVE(4), .V_ACTIVE(2)) dut_small (
    .clk   (clk),
    .reset (reset),
    .bus   (sbus)
  );

  // ---------------- clock / reset ----------------
  always #10 clk = ~clk;
  always @(posedge clk) cyc++;

  initial begin
    #1ms;
    $display("FAIL watchdog: simulation did not finish, checks=%0d", n_checks);
    $fatal(1);
  end

  // ---------------- SRAM models ----------------
  function automatic pixel_t pat(input fb_addr_t a);
    return a[15:0] ^ 16'hA5C3 ^ {a[19:16], 12'h000};
  endfunction

  always @(posedge clk) begin
    bus.sram_dq_i  <= !bus.sram_oe_n  ? pat(bus.sram_addr)  : 16'h0BAD;
    sbus.sram_dq_i <= !sbus.sram_oe_n ? pat(sbus.sram_addr) : 16'h0BAD;
  end

  // ---------------- checking ----------------
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  // ---------------- scoreboard / monitor (main instance) ----------------
  logic [15:0] exp_q[$];
  logic [35:0] wexp_q[$];
  logic [35:0] wmon;
  logic [15:0] pmon;
  fb_addr_t    rd_exp_addr = FB_BASE;
  int rd_issued = 0, wr_seen = 0, urun_seen = 0, n_pix = 0;
  int first_issue_cyc = -1, first_valid_cyc = -1;

  always @(negedge clk) begin
    if (!reset) begin
      if (!bus.sram_oe_n) begin
        check("rd_addr", bus.sram_addr, rd_exp_addr);
        rd_exp_addr = rd_exp_addr + 20'd1;
        rd_issued++;
        if (first_issue_cyc < 0) first_issue_cyc = cyc;
      end
      if (bus.pix_valid && first_valid_cyc < 0) first_valid_cyc = cyc;
      if (bus.wr_gnt || !bus.sram_we_n) begin
        wr_seen++;
        check("wr_expected", wexp_q.size() != 0, 1);
        if (wexp_q.size() != 0) begin
          wmon = wexp_q.pop_front();
          check("wr_addr", bus.sram_addr, wmon[35:16]);
          check("wr_data", bus.sram_dq_o, wmon[15:0]);
          check("wr_strobes", {bus.wr_gnt, bus.sram_we_n, bus.sram_dq_oe, bus.sram_oe_n}, 4'b1011);
        end
      end
      if (bus.pix_pop && !bus.frame_start) begin
        check("underrun_flag", bus.dbg_underrun, !bus.pix_valid);
        if (bus.dbg_underrun) urun_seen++;
        if (bus.pix_valid) begin
          check("pix_expected", exp_q.size() != 0, 1);
          if (exp_q.size() != 0) begin
            pmon = exp_q.pop_front();
            check("pix_data", bus.pix_data, pmon);
            n_pix++;
          end
        end
      end
      if (bus.frame_start) begin
        exp_q.delete();
        for (int i = 0; i < 128; i++) exp_q.push_back(pat(FB_BASE + fb_addr_t'(i)));
        rd_exp_addr = FB_BASE;
      end
    end
  end

  int srd_cnt = 0;
  always @(negedge clk) if (!reset && !sbus.sram_oe_n) srd_cnt++;

  // ---------------- drivers ----------------
  task automatic tick(input int n = 1);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic pulse_frame_start();
    bus.frame_start = 1'b1;
    tick();
    bus.frame_start = 1'b0;
  endtask

  // ---------------- stimulus ----------------
  int lat;
  logic [15:0] wd;

  initial begin
    bus.frame_start  = 1'b0; bus.pix_pop  = 1'b0; bus.wr_req  = 1'b0;
    bus.wr_addr      = '0;   bus.wr_data  = '0;
    sbus.frame_start = 1'b0; sbus.pix_pop = 1'b0; sbus.wr_req = 1'b0;
    sbus.wr_addr     = '0;   sbus.wr_data = '0;
    reset = 1'b1;
    tick(3);
    reset = 1'b0;
    #2;

    // reset state
    check("rst_strobes", {bus.sram_oe_n, bus.sram_we_n, bus.sram_dq_oe, bus.wr_gnt, bus.pix_valid}, 5'b11000);
    check("rst_addr", bus.sram_addr, 0);
    check("rst_dq_o", bus.sram_dq_o, 0);
    check("rst_pix_data", bus.pix_data, 0);
    check("rst_state", bus.dbg_state, IDLE);
    tick(2);
    check("idle_no_read", rd_issued, 0);

    // prefetch with no pops: eight reads, then nothing
    rd_issued = 0;
    pulse_frame_start();
    check("state_fetch", bus.dbg_state, FETCH);
    tick(20);
    check("prefetch_reads", rd_issued, 8);
    check("prefetch_oe_idle", bus.sram_oe_n, 1);
    check("valid_latency", first_valid_cyc - first_issue_cyc, 2);
    check("head_word", bus.pix_data, pat(FB_BASE));

    // steady drain, one pop every second cycle
    urun_seen = 0; wr_seen = 0; n_pix = 0;
    for (int i = 0; i < 20; i++) begin
      bus.pix_pop = 1'b1;
      tick();
      bus.pix_pop = 1'b0;
      tick();
    end
    check("drain_pops", n_pix, 20);
    check("drain_no_underrun", urun_seen, 0);
    check("drain_no_write", wr_seen, 0);

    // writer against a continuously requesting display
    pulse_frame_start();
    tick(2);
    bus.pix_pop = 1'b1;
    bus.wr_addr = 20'h12345;
    bus.wr_data = 16'hBEEF;
    wexp_q.push_back({20'h12345, 16'hBEEF});
    bus.wr_req  = 1'b1;
    lat = 0;
    while (lat < 40) begin
      tick();
      lat++;
      if (bus.wr_gnt) break;
    end
    bus.wr_req = 1'b0;
    check("wr_wait_latency", lat, MAX_WAIT + 1);
    check("wr_gnt_addr", bus.sram_addr, 20'h12345);
    check("wr_gnt_data", bus.sram_dq_o, 16'hBEEF);
    check("wr_gnt_we_oe", {bus.sram_we_n, bus.sram_dq_oe}, 2'b01);
    tick();
    bus.pix_pop = 1'b0;
    check("wr_gnt_pulse", bus.wr_gnt, 0);

    // frame_start with five buffered words and reads in flight
    pulse_frame_start();
    tick(14);
    check("full_valid", bus.pix_valid, 1);
    bus.pix_pop = 1'b1;
    tick(3);
    bus.pix_pop     = 1'b0;
    bus.frame_start = 1'b1;
    tick();
    bus.frame_start = 1'b0;
    check("flush_valid_1", bus.pix_valid, 0);
    tick();
    check("flush_valid_2", bus.pix_valid, 0);
    tick();
    check("flush_valid_3", bus.pix_valid, 0);
    tick();
    check("refill_valid", bus.pix_valid, 1);
    check("refill_word", bus.pix_data, pat(FB_BASE));

    // small frame: end of fetch, then back-to-back writes
    sbus.frame_start = 1'b1;
    tick();
    sbus.frame_start = 1'b0;
    tick(15);
    check("small_reads", srd_cnt, 8);
    check("small_done", sbus.dbg_state, DONE);
    for (int i = 0; i < 4; i++) begin
      wd = 16'($urandom_range(0, 65535));
      sbus.wr_req  = 1'b1;
      sbus.wr_addr = 20'h00100 + fb_addr_t'(i);
      sbus.wr_data = wd;
      tick();
      check("small_gnt", {sbus.wr_gnt, sbus.sram_we_n, sbus.sram_dq_oe}, 3'b101);
      check("small_wr_addr", sbus.sram_addr, 20'h00100 + fb_addr_t'(i));
      check("small_wr_data", sbus.sram_dq_o, wd);
    end
    sbus.wr_req = 1'b0;

    // asynchronous reset during a write strobe
    reset = 1'b1;
    #1;
    check("async_rst_strobes", {sbus.wr_gnt, sbus.sram_we_n, sbus.sram_dq_oe, sbus.sram_oe_n}, 4'b0101);
    check("async_rst_state", sbus.dbg_state, IDLE);
    tick(2);
    reset = 1'b0;
    tick();

    // pops on an empty FIFO
    urun_seen = 0;
    bus.pix_pop = 1'b1;
    tick(3);
    bus.pix_pop = 1'b0;
    tick();
    check("underrun_events", urun_seen, 3);
    check("underrun_data", bus.pix_data, 0);
`ifdef VGA_FB_UNDERRUN_CNT_EN
    check("underrun_cnt", bus.underrun_cnt, 3);
    pulse_frame_start();
    tick(3);
    check("underrun_cnt_kept", bus.underrun_cnt, 3);
`endif

    tick(2);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/vga_fb_arbiter.md
Name: vga_fb_arbiter

Overview:
- Shares one single-port 16-bit frame-buffer SRAM between two requesters.
- Requester 1: display fetch. Prefetches active pixels (640x480, one 16-bit word per pixel) into a small FIFO that the pixel pipeline drains.
- Requester 2: drawing-engine write port using a req/gnt handshake.
- Sits between the VGA timing generator / colour mapper and the SRAM pins. Runs on the 50 MHz clk, so there are 2 SRAM slots per 25 MHz pixel.

Parameters:
- FB_BASE, 20'h00000, SRAM word address of pixel (0,0).
- H_ACTIVE, 640, active pixels per line.
- V_ACTIVE, 480, active lines per frame.
- FIFO_DEPTH, 8, prefetch FIFO entries (power of two, >=4).
- MAX_WAIT, 16, cycles a pending write may be refused before it is forced.

Ports:
- clk  in  1  50 MHz system clock.
- reset  in  1  asynchronous, active-high.
- frame_start  in  1  one-clk pulse at start of a frame's fetch window (before line 0).
- pix_pop  in  1  consume FIFO head (one per visible pixel).
- pix_data  out  16  FIFO head; 0 when empty.
- pix_valid  out  1  FIFO non-empty.
- wr_req  in  1  drawing engine requests a write.
- wr_addr  in  20  write word address.
- wr_data  in  16  write data.
- wr_gnt  out  1  one-clk pulse: write issued this cycle; wr_* sampled.
- sram_addr  out  20  SRAM address.
- sram_oe_n  out  1  read enable, active low.
- sram_we_n  out  1  write enable, active low.
- sram_dq_o  out  16  write data.
- sram_dq_oe  out  1  drive data bus.
- sram_dq_i  in  16  read data, valid the cycle after issue.

Behaviour:
- Reset values:
  - sram_oe_n=1, sram_we_n=1, sram_dq_oe=0, sram_addr=0, sram_dq_o=0.
  - wr_gnt=0, pix_valid=0, pix_data=0.
  - FIFO empty, in-flight=0, wait counter=0, FSM=IDLE.
- All SRAM outputs are registered. Exactly one access or none per cycle.
- FSM states:
  - IDLE: no display fetch; writer may use every slot. frame_start -> FETCH.
  - FETCH: display fetch active. The last of H_ACTIVE*V_ACTIVE reads issued -> DONE.
  - DONE: writer owns all slots. frame_start -> FETCH.
- frame_start in any state:
  - FIFO flushed, fetch address := FB_BASE, fetch count := 0, in-flight read data discarded.
  - Takes priority over a same-cycle pix_pop (the pop is ignored).
- Display request (disp_req): state==FETCH and (fifo_count + inflight) < FIFO_DEPTH.
- Arbitration, each cycle:
  - If wait_cnt==MAX_WAIT and wr_req: the writer wins.
  - Else if disp_req: the display wins.
  - Else if wr_req: the writer wins.
- Wait counter:
  - Increments while wr_req=1 and the writer is not granted.
  - Clears on wr_gnt or when wr_req=0.
  - Saturates at MAX_WAIT.
- Read issue:
  - sram_addr=fetch address, sram_oe_n=0. Then fetch address += 1, fetch count += 1, inflight=1.
  - The next cycle sram_dq_i is pushed into the FIFO. The pushed word is visible at pix_data one cycle after that.
- Write issue:
  - sram_addr=wr_addr, sram_dq_o=wr_data, sram_dq_oe=1, sram_we_n=0, wr_gnt=1, all for one cycle.
  - wr_gnt and the SRAM strobes are asserted in the same cycle, registered from the arbitration decision.
  - Back-to-back grants are allowed.
- Read latency: from issue to pix_valid = 2 clk.
- FIFO:
  - Simultaneous push and pop leaves count unchanged.
  - The reservation rule prevents overflow, so push-when-full cannot occur.
- Underrun: pix_pop with FIFO empty is ignored. pix_data stays 0 and an internal underrun pulse is raised.
- Fetch count width: 19 bits, enough for 307200. No wrap: DONE is terminal until frame_start.
- Reset asserted mid-access: outputs return to reset values immediately (asynchronous), and no partial write strobe is extended.

Optional Feature:
- Macro: VGA_FB_UNDERRUN_CNT_EN.
- When defined:
  - Adds output underrun_cnt [15:0], a saturating count of underrun events.
  - Cleared by reset only, not by frame_start.
  - Holds at 16'hFFFF once saturated.
- When undefined: no port, no counter. Underruns are silently ignored.

Decomposition:
- Package vga_fb_pkg holds:
  - pixel_t (logic [15:0]) and fb_addr_t (logic [19:0]).
  - Enum fb_state_e {IDLE, FETCH, DONE}.
  - Localparam FB_WORDS = H_ACTIVE*V_ACTIVE.
- One sub-module: vga_fb_fifo, a synchronous FIFO parameterised by depth and width.
  - Ports: push, pop, din, dout, count, flush.
  - dout is 0 when empty.

Test Plan:
- Reset, then frame_start with pix_pop=0:
  - Exactly 8 reads are issued at addresses 0..7, then oe_n stays 1.
  - pix_valid rises 2 clk after the first issue.
  - pix_data=mem[0].
- Steady drain, pop every 2nd clk for 20 pixels:
  - pix_data sequence equals mem[0..19].
  - No underrun.
  - Free slots are unused when wr_req=0.
- wr_req held high with addr 0x12345, data 0xBEEF, display continuously requesting:
  - wr_gnt is asserted no later than 17 clk after wr_req.
  - Same cycle: we_n=0, dq_oe=1, sram_addr=0x12345, sram_dq_o=0xBEEF.
- End of frame, small V_ACTIVE=2/H_ACTIVE=4 build:
  - After 8 reads the FSM is DONE.
  - Consecutive writes get wr_gnt every cycle.
- frame_start mid-fetch with FIFO holding 5 entries and a read in flight:
  - Next cycle pix_valid=0.
  - The next read address is FB_BASE.
  - The stale in-flight word is not pushed.
- With VGA_FB_UNDERRUN_CNT_EN: 3 pops on an empty FIFO -> underrun_cnt=3. A following frame_start leaves it at 3.
